// File: rtl/sram_fifo_arbiter.sv
// sram_fifo_arbiter: shares one sram_fifo between NUM_SRC round-robin write
// sources and a single read sink. Reads win at the FIFO; a burst limiter
// inserts a one-cycle read bubble so a pending write can get through.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   src_wr_req/data/ack       per-source write handshake (ack is a 1-cycle pulse)
//   snk_rd_req                sink read request
//   snk_rd_data_val/data/empty  FIFO read side passed straight through
//   fifo_*                    FIFO control/data (this block is the only driver)
//   grant_id, grant_vld       current grant (registered)
//
// Optional build macro SRAM_FIFO_ARB_STATS_EN adds stall_cnt[15:0]: saturating
// count of granted cycles without a FIFO write acknowledge.
module sram_fifo_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_RD_BURST = 4,
  localparam int unsigned SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_wr_req,
  input  logic [NUM_SRC*DATA_W-1:0] src_wr_data,
  output logic [NUM_SRC-1:0]        src_wr_ack,
  input  logic                      snk_rd_req,
  output logic                      snk_rd_data_val,
  output logic [DATA_W-1:0]         snk_rd_data,
  output logic                      snk_empty,
  output logic                      fifo_wr_req,
  output logic [DATA_W-1:0]         fifo_wr_data,
  input  logic                      fifo_wr_ack,
  output logic                      fifo_rd_req,
  input  logic                      fifo_rd_data_val,
  input  logic [DATA_W-1:0]         fifo_rd_data,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic [SRC_W-1:0]          grant_id,
  output logic                      grant_vld
`ifdef SRAM_FIFO_ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_RD_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   grant_id_nxt;
  logic [SRC_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [SRC_W-1:0]   ptr_inc;
  logic [NUM_SRC-1:0] pending;
  logic               wr_fire;
  logic [CNT_W-1:0]   rd_burst_cnt;
  logic               rd_block;

  // Full is handled by the FIFO withholding its ack; the arbiter never looks at it.
  logic unused_ok;
  assign unused_ok = fifo_full;

  // First requester at or after start, increasing index with wrap.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0]   start);
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] sel;
    logic             found;
    int unsigned      idx;
    pick  = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(start) + k) % NUM_SRC;
      sel = SRC_W'(idx);
      if (!found && req[sel]) begin
        pick  = sel;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Read side: pass-through, only gated by empty and the burst limiter.
  assign snk_rd_data_val = fifo_rd_data_val;
  assign snk_rd_data     = fifo_rd_data;
  assign snk_empty       = fifo_empty;
  assign fifo_rd_req     = snk_rd_req & ~fifo_empty & ~rd_block;

  // Write side: the FIFO ignores writes during reads, so mask them.
  assign grant_vld   = (state == GRANT);
  assign fifo_wr_req = grant_vld & src_wr_req[grant_id] & ~fifo_rd_req;
  assign wr_fire     = fifo_wr_req & fifo_wr_ack;
  assign ptr_inc     = (grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
  assign pending     = src_wr_req & ~(NUM_SRC'(1) << grant_id);

  // Write data mux keyed by the registered grant.
  always_comb begin
    fifo_wr_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_id == SRC_W'(i)) fifo_wr_data = src_wr_data[i*DATA_W +: DATA_W];
    end
  end

  // FSM state and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // Next-state, arbitration and ack pulse.
  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    rr_ptr_nxt   = rr_ptr;
    src_wr_ack   = '0;
    case (state)
      IDLE: begin
        if (|src_wr_req) begin
          state_nxt    = GRANT;
          grant_id_nxt = rr_pick(src_wr_req, rr_ptr);
        end
      end
      GRANT: begin
        if (wr_fire) begin
          src_wr_ack = NUM_SRC'(1) << grant_id;
          rr_ptr_nxt = ptr_inc;
          if (|pending) grant_id_nxt = rr_pick(pending, ptr_inc);
          else          state_nxt    = IDLE;
        end else if (!src_wr_req[grant_id]) begin
          // Request withdrawn before ack: drop the grant, keep rr_ptr.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst limiter: block exactly one read cycle after MAX_RD_BURST reads
  // back-to-back while a write is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_burst_cnt <= '0;
      rd_block     <= 1'b0;
    end else begin
      rd_block <= 1'b0;
      if (!fifo_rd_req) begin
        rd_burst_cnt <= '0;
      end else if (grant_vld && rd_burst_cnt >= BURST_LAST) begin
        rd_block     <= 1'b1;
        rd_burst_cnt <= '0;
      end else if (rd_burst_cnt != {CNT_W{1'b1}}) begin
        rd_burst_cnt <= rd_burst_cnt + 1'b1;
      end
    end
  end

`ifdef SRAM_FIFO_ARB_STATS_EN
  // Saturating count of granted cycles with no write acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (grant_vld && !fifo_wr_ack && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Directed bench for sram_fifo_arbiter (NUM_SRC=4, DATA_W=32, MAX_RD_BURST=4).
// A minimal FIFO model acks any write request while not full.
module tb_sram_fifo_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    src_wr_req;
  logic [N*DW-1:0] src_wr_data;
  logic [N-1:0]    src_wr_ack;
  logic            snk_rd_req;
  logic            snk_rd_data_val;
  logic [DW-1:0]   snk_rd_data;
  logic            snk_empty;
  logic            fifo_wr_req;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_ack;
  logic            fifo_rd_req;
  logic            fifo_rd_data_val;
  logic [DW-1:0]   fifo_rd_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      grant_id;
  logic            grant_vld;
`ifdef SRAM_FIFO_ARB_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  sram_fifo_arbiter #(.NUM_SRC(N), .DATA_W(DW), .MAX_RD_BURST(MB)) dut (
    .clk              (clk),
    .rst              (rst),
    .src_wr_req       (src_wr_req),
    .src_wr_data      (src_wr_data),
    .src_wr_ack       (src_wr_ack),
    .snk_rd_req       (snk_rd_req),
    .snk_rd_data_val  (snk_rd_data_val),
    .snk_rd_data      (snk_rd_data),
    .snk_empty        (snk_empty),
    .fifo_wr_req      (fifo_wr_req),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr_ack      (fifo_wr_ack),
    .fifo_rd_req      (fifo_rd_req),
    .fifo_rd_data_val (fifo_rd_data_val),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .grant_id         (grant_id),
    .grant_vld        (grant_vld)
`ifdef SRAM_FIFO_ARB_STATS_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  // FIFO model: combinational ack whenever not full.
  assign fifo_wr_ack = fifo_wr_req & ~fifo_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven just after the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    src_wr_req = '0;
    snk_rd_req = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int unsigned order [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < int'(N); i++) src_wr_data[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
    fifo_rd_data_val = 1'b0;
    fifo_rd_data     = '0;
    do_reset();
    rst = 1'b1;
    #1;
    // Reset values
    chk("rst_grant_vld", 32'(grant_vld), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_ack", 32'(src_wr_ack), 0);
    chk("rst_wr_req", 32'(fifo_wr_req), 0);
    chk("rst_rd_req", 32'(fifo_rd_req), 0);
    cyc();
    rst = 1'b0;

    // Read pass-through and empty gating
    snk_rd_req       = 1'b1;
    fifo_rd_data_val = 1'b1;
    fifo_rd_data     = 32'hDEAD_BEEF;
    #1;
    chk("rd_gated_empty", 32'(fifo_rd_req), 0);
    chk("snk_data", snk_rd_data, 32'hDEAD_BEEF);
    chk("snk_val", 32'(snk_rd_data_val), 1);
    chk("snk_empty", 32'(snk_empty), 1);
    fifo_empty = 1'b0;
    #1;
    chk("rd_req_pass", 32'(fifo_rd_req), 1);
    snk_rd_req       = 1'b0;
    fifo_empty       = 1'b1;
    fifo_rd_data_val = 1'b0;
    cyc();

    // Single write from src 2
    src_wr_req = 4'b0100;
    #1;
    chk("sw_wr_req_idle", 32'(fifo_wr_req), 0);
    cyc();
    #1;
    chk("sw_grant_vld", 32'(grant_vld), 1);
    chk("sw_grant_id", 32'(grant_id), 2);
    chk("sw_wr_req", 32'(fifo_wr_req), 1);
    chk("sw_wr_data", fifo_wr_data, 32'hA5A5_0002);
    chk("sw_ack", 32'(src_wr_ack), 32'b0100);
    cyc();
    src_wr_req = '0;
    #1;
    chk("sw_idle", 32'(grant_vld), 0);

    // Request withdrawn (rr_ptr is now 3)
    fifo_full  = 1'b1;
    src_wr_req = 4'b0010;
    cyc();
    #1;
    chk("wd_grant_vld", 32'(grant_vld), 1);
    chk("wd_grant_id", 32'(grant_id), 1);
    src_wr_req = '0;
    #1;
    chk("wd_no_ack", 32'(src_wr_ack), 0);
    cyc();
    #1;
    chk("wd_idle", 32'(grant_vld), 0);
    chk("wd_idle_ack", 32'(src_wr_ack), 0);
    fifo_full  = 1'b0;
    src_wr_req = 4'b1100;
    cyc();
    #1;
    chk("wd_ptr_kept_id", 32'(grant_id), 3);
    chk("wd_ptr_kept_ack", 32'(src_wr_ack), 32'b1000);
    cyc();
    src_wr_req = 4'b0100;
    #1;
    chk("wd_next_id", 32'(grant_id), 2);
    chk("wd_next_ack", 32'(src_wr_ack), 32'b0100);
    cyc();
    src_wr_req = '0;
    cyc();

    // All sources held: grants 0,1,2,3,0 back to back
    do_reset();
    src_wr_req = 4'b1111;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_id%0d", k), 32'(grant_id), order[k]);
      chk($sformatf("rr_ack%0d", k), 32'(src_wr_ack), 32'(1) << order[k]);
      chk($sformatf("rr_data%0d", k), fifo_wr_data, 32'hA5A5_0000 | order[k]);
      cyc();
    end
    src_wr_req = '0;
    cyc();

    // Starvation guard: 4 reads, one write gap, reads resume
    do_reset();
    fifo_empty = 1'b0;
    snk_rd_req = 1'b1;
    src_wr_req = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("sg_rd%0d", c), 32'(fifo_rd_req), (c == 4) ? 0 : 1);
      chk($sformatf("sg_wr%0d", c), 32'(fifo_wr_req), (c == 4) ? 1 : 0);
      chk($sformatf("sg_ack%0d", c), 32'(src_wr_ack), (c == 4) ? 32'b0010 : 0);
      if (c == 4) chk("sg_data", fifo_wr_data, 32'hA5A5_0001);
      cyc();
      if (c == 4) src_wr_req = '0;
    end
    snk_rd_req = 1'b0;
    fifo_empty = 1'b1;
    cyc();

    // Full FIFO: grant holds without ack, then one pop lets it through
    do_reset();
    fifo_full  = 1'b1;
    src_wr_req = 4'b0001;
    cyc();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("full_vld%0d", c), 32'(grant_vld), 1);
      chk($sformatf("full_ack%0d", c), 32'(src_wr_ack), 0);
      cyc();
    end
`ifdef SRAM_FIFO_ARB_STATS_EN
    #1;
    chk("stall_held", 32'(stall_cnt), 3);
`endif
    fifo_full = 1'b0;
    #1;
    chk("full_pop_ack", 32'(src_wr_ack), 32'b0001);
    cyc();
    src_wr_req = '0;
    #1;
    chk("full_idle", 32'(grant_vld), 0);
`ifdef SRAM_FIFO_ARB_STATS_EN
    chk("stall_after", 32'(stall_cnt), 3);
`endif

    // Reset mid-grant with src 3 granted
    fifo_full  = 1'b1;
    src_wr_req = 4'b1000;
    cyc();
    #1;
    chk("rm_grant_id", 32'(grant_id), 3);
    chk("rm_grant_vld", 32'(grant_vld), 1);
    rst = 1'b1;
    #1;
    chk("rm_drop_vld", 32'(grant_vld), 0);
    chk("rm_no_ack", 32'(src_wr_ack), 0);
    chk("rm_no_wr", 32'(fifo_wr_req), 0);
    cyc();
    rst        = 1'b0;
    fifo_full  = 1'b0;
    src_wr_req = 4'b1001;
    cyc();
    #1;
    chk("rm_first_id", 32'(grant_id), 0);
    chk("rm_first_ack", 32'(src_wr_ack), 32'b0001);
    cyc();
    src_wr_req = 4'b1000;
    #1;
    chk("rm_second_id", 32'(grant_id), 3);
    chk("rm_second_ack", 32'(src_wr_ack), 32'b1000);
    cyc();
    src_wr_req = '0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
